gshare_btb_predictor: RTL
=========================

# gshare_btb_predictor

Parametrised next-PC and branch-prediction unit for the pipelined RV32 core, replacing the fixed 14-bit-indexed gshare and hard-wired PC multiplexer. Combines a speculatively updated global history register (GHR), a configurable pattern history table (PHT), and a direct-mapped branch target buffer (BTB). Produces the fetch-stage next PC. Accepts resolved branches from EX and recovers the GHR on misprediction.

## Interface
- XLEN, 32: address width.
- GHR_W, 8: global history length in bits; must be ≤ PHT_IDX_W.
- PHT_IDX_W, 10: log2 of PHT entries (2-bit counters).
- BTB_IDX_W, 6: log2 of BTB entries.

Clock, reset and ports:
- One clock; reset is asynchronous and active-high.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch PC valid.
- f_stall  in  1  fetch stalled; PC and GHR hold.
- f_pc  in  XLEN  current fetch PC.
- f_pred_taken  out  1  prediction for f_pc.
- f_pred_target  out  XLEN  predicted target (BTB target, or f_pc+4 when not taken).
- f_ghr  out  GHR_W  GHR snapshot before this fetch; travels down the pipeline with the instruction.
- next_pc  out  XLEN  PC register input.
- ex_valid  in  1  EX instruction valid (not flushed).
- ex_is_branch  in  1  EX holds a conditional branch.
- ex_pc  in  XLEN  branch PC.
- ex_taken  in  1  resolved outcome.
- ex_target  in  XLEN  resolved taken target.
- ex_pred_taken  in  1  prediction carried from fetch.
- ex_pred_target  in  XLEN  target carried from fetch.
- ex_ghr  in  GHR_W  snapshot carried from fetch.
- ex_mispredict  out  1  redirect and flush F/DE.
- stat_branches  out  32  resolved-branch count.
- stat_mispredicts  out  32  mispredict count.

## Operation
Fetch-side lookup:
- PHT index = f_pc[PHT_IDX_W+1:2] XOR zero-extended GHR.
- BTB index = f_pc[BTB_IDX_W+1:2].
- BTB tag = f_pc[XLEN-1:BTB_IDX_W+2].
- f_pred_taken = BTB valid AND tag match AND PHT counter[1].

Speculative GHR update:
- When f_valid, !f_stall, BTB hit and no ex_mispredict: GHR <= {GHR[GHR_W-2:0], f_pred_taken}.
- Only BTB-hit PCs shift the GHR.

Resolution:
- ex_mispredict = ex_valid AND ex_is_branch AND (ex_taken ≠ ex_pred_taken OR (ex_taken AND ex_target ≠ ex_pred_target)).

Update on ex_valid AND ex_is_branch:
- PHT: the entry indexed with ex_pc and ex_ghr saturates up when taken, down when not. Saturates at 2'b11 and 2'b00; no wrap.
- BTB: when ex_taken, write {valid=1, tag, ex_target} to the entry.
- Not-taken branches never allocate a BTB entry.

Mispredict recovery:
- GHR <= {ex_ghr[GHR_W-2:0], ex_taken}, only if the ex_pc BTB entry hit at fetch (ex_pred_taken OR the entry is present); otherwise GHR <= ex_ghr.

next_pc priority:
1. ex_mispredict: ex_taken ? ex_target : ex_pc+4.
2. f_stall: f_pc.
3. f_pred_taken: BTB target.
4. Otherwise: f_pc+4.

Address arithmetic is modulo 2^XLEN.

## Timing
- Lookup, f_pred_*, next_pc and ex_mispredict are combinational; zero latency.
- PHT, BTB and GHR writes take effect at the next rising clk. A same-cycle fetch lookup of an entry under update sees the old value.
- Mispredict and a fetch-side GHR shift in the same cycle: the mispredict restore wins and the fetch shift is dropped.
- Async rst, including mid-operation:
  - GHR = 0.
  - Every PHT counter = 2'b01 (weakly not-taken).
  - All BTB valid = 0.
  - Stat counters = 0.
  - Outputs settle to not-taken, next_pc = f_pc+4.
- No state changes while ex_valid = 0 and f_stall = 1.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every ex_valid AND ex_is_branch.
  - stat_mispredicts increments on every ex_mispredict.
  - Both are 32-bit wrapping counters.
- BP_STATS_EN undefined: both outputs tied to 0 and no counter flops are built. The ports always exist.

## Structure
- bp_pkg holds:
  - Counter typedef.
  - Constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - BTB entry struct {valid, tag, target}, parametrised via localparams in the top.
- Sub-module bp_btb: direct-mapped tag/target array with async clear, combinational read, one write port.
- PHT, GHR and next-PC mux remain in the top.

## Test plan
- Reset, then f_pc=0x100 → f_pred_taken=0, next_pc=0x104, f_ghr=0.
- Resolve taken branch at 0x100 to 0x80 twice (first resolution mispredicts) → ex_mispredict=1 then next_pc=0x80. After both updates, fetch 0x100 with matching GHR → f_pred_taken=1, next_pc=0x80.
- Resolve four not-taken on a strongly-taken entry → counter goes 11→10→01→00 and stays at 00. Prediction flips at the second update.
- Predicted-taken branch resolves not-taken with ex_ghr=8'hA5 → next_pc=ex_pc+4, GHR=8'h4A next cycle. A simultaneous fetch-side shift is discarded.
- Assert rst mid-sequence with a populated BTB → next cycle all lookups predict not-taken, GHR=0, stats=0.
- With BP_STATS_EN, resolve 10 branches with 3 mispredicts → stat_branches=10, stat_mispredicts=3. Without the macro → both 0.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the gshare/BTB branch predictor.
//   ctr_t          : 2-bit saturating pattern-history counter
//   SNT/WNT/WT/ST  : counter encodings (strongly/weakly not-taken/taken)
//   ctr_update()   : saturating counter step toward the resolved outcome
// The BTB entry struct depends on XLEN/BTB_IDX_W, so it is declared in the top
// from its localparams and handed to bp_btb as a type parameter.
// -----------------------------------------------------------------------------
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Saturating step: never wraps past ST or SNT.
    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'b01);
        end
        return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// -----------------------------------------------------------------------------
// bp_btb
// Direct-mapped branch target buffer storage: 2**IDX_W entries of entry_t,
// asynchronous clear, two combinational read ports, one synchronous write port.
// A read of an entry being written in the same cycle returns the old contents.
// Ports:
//   clk, rst              clock, asynchronous active-high clear
//   i_rd_a_idx / o_rd_a   read port A (fetch lookup)
//   i_rd_b_idx / o_rd_b   read port B (EX-side presence check)
//   i_wr_en, i_wr_idx,
//   i_wr_data             write port (resolved taken branch)
// -----------------------------------------------------------------------------
module bp_btb #(
    parameter int  IDX_W   = 6,
    parameter type entry_t = logic [0:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_a_idx,
    output entry_t           o_rd_a,
    input  logic [IDX_W-1:0] i_rd_b_idx,
    output entry_t           o_rd_b,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  entry_t           i_wr_data
);

    localparam int DEPTH = 1 << IDX_W;

    entry_t r_mem [DEPTH];

    // NOTE: the array lives in flops so it can be cleared asynchronously; this
    // rules out mapping it onto an SRAM macro, which cannot be reset in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_a = r_mem[i_rd_a_idx];
    assign o_rd_b = r_mem[i_rd_b_idx];

endmodule

// File: rtl/gshare_btb_predictor.sv
// -----------------------------------------------------------------------------
// gshare_btb_predictor
// Next-PC and branch-prediction unit: speculative global history register,
// gshare pattern history table of 2-bit counters, direct-mapped BTB (bp_btb).
// Optional feature macro: BP_STATS_EN builds the resolved-branch and mispredict
// counters; without it stat_* are tied to zero and no counter flops exist.
// Ports:
//   clk, rst                           clock, asynchronous active-high reset
//   f_valid, f_stall, f_pc             fetch request
//   f_pred_taken, f_pred_target, f_ghr fetch prediction and history snapshot
//   next_pc                            PC register input
//   ex_valid, ex_is_branch, ex_pc,
//   ex_taken, ex_target,
//   ex_pred_taken, ex_pred_target,
//   ex_ghr                             resolved branch from EX
//   ex_mispredict                      redirect / flush F and DE
//   stat_branches, stat_mispredicts    statistics counters
// -----------------------------------------------------------------------------
module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int GHR_W     = 8,
    parameter int PHT_IDX_W = 10,
    parameter int BTB_IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic            f_stall,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    output logic [GHR_W-1:0] f_ghr,
    output logic [XLEN-1:0] next_pc,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic [GHR_W-1:0] ex_ghr,
    output logic            ex_mispredict,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int TAG_W     = XLEN - BTB_IDX_W - 2;
    localparam int PHT_DEPTH = 1 << PHT_IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btb_entry_t;

    logic [GHR_W-1:0] r_ghr;
    ctr_t             r_pht [PHT_DEPTH];

    logic [PHT_IDX_W-1:0] w_f_pht_idx, w_ex_pht_idx;
    logic [BTB_IDX_W-1:0] w_f_btb_idx, w_ex_btb_idx;
    logic [TAG_W-1:0]     w_f_tag, w_ex_tag;
    btb_entry_t           w_f_entry, w_ex_entry, w_wr_entry;
    logic                 w_f_hit, w_ex_hit, w_ex_resolve;
    logic [XLEN-1:0]      w_f_pc_plus4, w_ex_pc_plus4;

    // ---------------- fetch-side lookup ----------------
    assign w_f_pht_idx  = f_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
    assign w_f_btb_idx  = f_pc[BTB_IDX_W+1:2];
    assign w_f_tag      = f_pc[XLEN-1:BTB_IDX_W+2];
    assign w_f_pc_plus4 = f_pc + XLEN'(4);

    assign w_f_hit       = w_f_entry.valid && (w_f_entry.tag == w_f_tag);
    assign f_pred_taken  = w_f_hit && r_pht[w_f_pht_idx][1];
    assign f_pred_target = f_pred_taken ? w_f_entry.target : w_f_pc_plus4;
    assign f_ghr         = r_ghr;

    // ---------------- EX-side resolution ----------------
    assign w_ex_pht_idx  = ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ex_ghr);
    assign w_ex_btb_idx  = ex_pc[BTB_IDX_W+1:2];
    assign w_ex_tag      = ex_pc[XLEN-1:BTB_IDX_W+2];
    assign w_ex_pc_plus4 = ex_pc + XLEN'(4);
    assign w_ex_resolve  = ex_valid && ex_is_branch;
    // Presence check for GHR recovery: did this branch shift the GHR at fetch?
    assign w_ex_hit      = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

    assign ex_mispredict = w_ex_resolve &&
                           ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_target != ex_pred_target)));

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_pc = w_f_pc_plus4;
        if (ex_mispredict) begin
            next_pc = ex_taken ? ex_target : w_ex_pc_plus4;
        end else if (f_stall) begin
            next_pc = f_pc;
        end else if (f_pred_taken) begin
            next_pc = w_f_entry.target;
        end
    end

    // ---------------- BTB ----------------
    assign w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, target: ex_target};

    bp_btb #(
        .IDX_W   (BTB_IDX_W),
        .entry_t (btb_entry_t)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .i_rd_a_idx (w_f_btb_idx),
        .o_rd_a     (w_f_entry),
        .i_rd_b_idx (w_ex_btb_idx),
        .o_rd_b     (w_ex_entry),
        .i_wr_en    (w_ex_resolve && ex_taken),
        .i_wr_idx   (w_ex_btb_idx),
        .i_wr_data  (w_wr_entry)
    );

    // ---------------- PHT ----------------
    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values; the fetch lookup this cycle therefore sees the old counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= WNT;
            end
        end else if (w_ex_resolve) begin
            r_pht[w_ex_pht_idx] <= ctr_update(r_pht[w_ex_pht_idx], ex_taken);
        end
    end

    // ---------------- GHR ----------------
    // Recovery takes priority over the speculative fetch shift. The resolved
    // outcome is re-shifted only if this branch had shifted it at fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (ex_mispredict) begin
            r_ghr <= (ex_pred_taken || w_ex_hit) ? {ex_ghr[GHR_W-2:0], ex_taken} : ex_ghr;
        end else if (f_valid && !f_stall && w_f_hit) begin
            r_ghr <= {r_ghr[GHR_W-2:0], f_pred_taken};
        end
    end

    // ---------------- statistics ----------------
`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches, r_stat_mispredicts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_ex_resolve)  r_stat_branches    <= r_stat_branches + 32'd1;
            if (ex_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
